// File: rtl/dl_pkg.sv
// dl_pkg: shared constants and types for the ROM download router
package dl_pkg;
    localparam logic [1:0] DL_LINEAR  = 2'd0;
    localparam logic [1:0] DL_IL2     = 2'd1;
    localparam logic [1:0] DL_IL4     = 2'd2;
    localparam logic [1:0] DL_DISCARD = 2'd3;
    localparam int DL_AW = 25;
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DECODE   = 2'd1,
        ST_WAIT_ACK = 2'd2
    } dl_state_e;
    typedef struct packed {
        logic [DL_AW-1:0] base;
        logic [1:0]       mode;
        logic [4:0]       lg2;
        logic [1:0]       port;
    } dl_region_t;
endpackage

// File: rtl/dl_swizzle.sv
// dl_swizzle: rewrites a region offset so interleaved chunks land on adjacent bytes
module dl_swizzle
    import dl_pkg::*;
(
    input  logic [DL_AW-1:0] off_i,
    input  logic [1:0]       mode_i,
    input  logic [4:0]       lg2_i,
    output logic [DL_AW-1:0] sw_o
);
    logic [DL_AW-1:0] m1, m2, m4, lo, sh;
    // Move the chunk-select bit(s) at lg2 to the bottom, shifting the in-chunk bits up
    always_comb begin
        m1 = (DL_AW'(1) << lg2_i) - DL_AW'(1);
        m2 = (m1 << 1) | DL_AW'(1);
        m4 = (m1 << 2) | DL_AW'(3);
        lo = off_i & m1;
        sh = off_i >> lg2_i;
        sw_o = mode_i == DL_IL2 ? (off_i & ~m2) | (lo << 1) | (sh & DL_AW'(1)) :
               mode_i == DL_IL4 ? (off_i & ~m4) | (lo << 2) | (sh & DL_AW'(3)) : off_i;
    end
endmodule

// File: rtl/rom_dl_router.sv
// rom_dl_router: routes ioctl download bytes to SDRAM ports and generates core reset
module rom_dl_router
    import dl_pkg::*;
#(
    parameter int NREGIONS    = 4,
    parameter int NPORTS      = 2,
    parameter int SDRAM_AW    = 24,
    parameter int ACK_TIMEOUT = 1023,
    parameter int RST_HOLD    = 65535
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    ioctl_downl,
    input  logic                    ioctl_wr,
    input  logic [24:0]             ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    output logic                    ioctl_ack,
    input  logic [NREGIONS*25-1:0]  region_base,
    input  logic [NREGIONS*2-1:0]   region_mode,
    input  logic [NREGIONS*5-1:0]   region_lg2,
    input  logic [NREGIONS*2-1:0]   region_port,
    output logic [NPORTS-1:0]       port_req,
    input  logic [NPORTS-1:0]       port_ack,
    output logic [SDRAM_AW-1:0]     port_a,
    output logic [1:0]              port_ds,
    output logic [15:0]             port_d,
    input  logic                    user_reset,
    output logic                    rom_loaded,
    output logic                    core_reset,
    output logic                    err_overrun,
    output logic                    err_timeout
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(RST_HOLD + 1);
    dl_state_e state_q, state_d;
    logic [DL_AW-1:0] addr_q, addr_d;
    logic [7:0] dout_q, dout_d;
    logic [3:0] req_q, req_d, ack_ext;
    logic [1:0] pidx_q, pidx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [SDRAM_AW-1:0] a_q, a_d, pa;
    logic [1:0] ds_q, ds_d;
    logic [15:0] d_q, d_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic wr_q, downl_q, ack_q, ack_d, issued_q, issued_d, loaded_q, loaded_d;
    logic core_q, core_d, ovr_q, ovr_d, tmo_q, tmo_d;
    logic rise, fall, below, discard, acked;
    dl_region_t sel;
    logic [DL_AW-1:0] off, sw;
    // Highest region whose base does not exceed the latched address wins
    always_comb begin
        sel = '{base: region_base[DL_AW-1:0], mode: region_mode[1:0], lg2: region_lg2[4:0], port: region_port[1:0]};
        for (int i = 1; i < NREGIONS; i++)
            if (region_base[i*DL_AW +: DL_AW] <= addr_q)
                sel = '{base: region_base[i*DL_AW +: DL_AW], mode: region_mode[i*2 +: 2], lg2: region_lg2[i*5 +: 5], port: region_port[i*2 +: 2]};
    end
    // Pad acks to four bits so any 2-bit port index stays in range
    always_comb begin
        ack_ext = '0;
        ack_ext[NPORTS-1:0] = port_ack;
    end
    dl_swizzle u_swizzle (.off_i(off), .mode_i(sel.mode), .lg2_i(sel.lg2), .sw_o(sw));
    assign off = addr_q - sel.base;
    assign pa = SDRAM_AW'(sel.base + sw);
    assign below = addr_q < region_base[DL_AW-1:0];
    assign discard = below || sel.mode == DL_DISCARD;
    assign acked = req_q[pidx_q] == ack_ext[pidx_q];
    assign rise = ioctl_wr & ~wr_q;
    assign fall = downl_q & ~ioctl_downl;
    // Byte FSM, sticky errors, rom_loaded tracking and delayed core reset
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        dout_d = dout_q;
        req_d = req_q;
        pidx_d = pidx_q;
        tcnt_d = tcnt_q;
        a_d = a_q;
        ds_d = ds_q;
        d_d = d_q;
        ack_d = 1'b0;
        issued_d = issued_q;
        ovr_d = ovr_q | (rise & (state_q != ST_IDLE));
        tmo_d = tmo_q;
        case (state_q)
            ST_IDLE: if (rise && ioctl_downl) begin
                addr_d = ioctl_addr;
                dout_d = ioctl_dout;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = discard ? ST_IDLE : ST_WAIT_ACK;
                ack_d = discard;
                if (!discard) begin
                    req_d[sel.port] = ~req_q[sel.port];
                    pidx_d = sel.port;
                    a_d = pa;
                    ds_d = {pa[0], ~pa[0]};
                    d_d = {dout_q, dout_q};
                    tcnt_d = '0;
                    issued_d = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                tcnt_d = tcnt_q + TW'(1);
                if (acked || tcnt_q == TW'(ACK_TIMEOUT)) begin
                    state_d = ST_IDLE;
                    ack_d = 1'b1;
                    tmo_d = tmo_q | ~acked;
                    req_d[pidx_q] = ack_ext[pidx_q];
                end
            end
            default: state_d = ST_IDLE;
        endcase
        loaded_d = loaded_q | (fall & issued_d);
        issued_d = issued_d & ~fall;
        rcnt_d = (user_reset || !loaded_q) ? RW'(RST_HOLD) : rcnt_q - RW'(rcnt_q != '0);
        core_d = user_reset | ioctl_downl | ~loaded_q | (rcnt_q == RW'(1));
    end
    // State registers, cleared synchronously by reset_n
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q <= '0;
            dout_q <= '0;
            req_q <= '0;
            pidx_q <= '0;
            tcnt_q <= '0;
            a_q <= '0;
            ds_q <= '0;
            d_q <= '0;
            rcnt_q <= '0;
            wr_q <= 1'b0;
            downl_q <= 1'b0;
            ack_q <= 1'b0;
            issued_q <= 1'b0;
            loaded_q <= 1'b0;
            core_q <= 1'b1;
            ovr_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            dout_q <= dout_d;
            req_q <= req_d;
            pidx_q <= pidx_d;
            tcnt_q <= tcnt_d;
            a_q <= a_d;
            ds_q <= ds_d;
            d_q <= d_d;
            rcnt_q <= rcnt_d;
            wr_q <= ioctl_wr;
            downl_q <= ioctl_downl;
            ack_q <= ack_d;
            issued_q <= issued_d;
            loaded_q <= loaded_d;
            core_q <= core_d;
            ovr_q <= ovr_d;
            tmo_q <= tmo_d;
        end
    end
    assign ioctl_ack = ack_q;
    assign port_req = req_q[NPORTS-1:0];
    assign port_a = a_q;
    assign port_ds = ds_q;
    assign port_d = d_q;
    assign rom_loaded = loaded_q;
    assign core_reset = core_q;
    assign err_overrun = ovr_q;
    assign err_timeout = tmo_q;
endmodule

// File: tb/tb_rom_dl_router.sv
// tb_rom_dl_router: scoreboard bench for the ROM download router
module tb_rom_dl_router;
    localparam int NR = 4, NP = 2, AW = 24, RH = 40;
    typedef struct packed {
        logic [1:0]  port;
        logic [23:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } txn_t;
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    logic ioctl_downl = 1'b0;
    logic ioctl_wr = 1'b0;
    logic user_reset = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0] ioctl_dout = '0;
    logic ioctl_ack, rom_loaded, core_reset, err_overrun, err_timeout;
    logic [NR*25-1:0] region_base;
    logic [NR*2-1:0] region_mode, region_port;
    logic [NR*5-1:0] region_lg2;
    logic [NP-1:0] port_req, port_ack, hold, prev_req;
    logic [AW-1:0] port_a;
    logic [1:0] port_ds;
    logic [15:0] port_d;
    txn_t exp_q[$];
    int checks = 0, failures = 0;

    rom_dl_router #(.NREGIONS(NR), .NPORTS(NP), .SDRAM_AW(AW), .ACK_TIMEOUT(15), .RST_HOLD(RH)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_ack(ioctl_ack),
        .region_base(region_base), .region_mode(region_mode), .region_lg2(region_lg2),
        .region_port(region_port), .port_req(port_req), .port_ack(port_ack), .port_a(port_a),
        .port_ds(port_ds), .port_d(port_d), .user_reset(user_reset), .rom_loaded(rom_loaded),
        .core_reset(core_reset), .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input logic [1:0] p, input logic [23:0] a, input logic [1:0] ds, input logic [15:0] d);
        exp_q.push_back('{port: p, a: a, ds: ds, d: d});
    endtask

    // Monitor pops the scoreboard on every new request, then the SDRAM model acks unless held
    always @(negedge clk_sys) begin : mon
        txn_t e;
        for (int p = 0; p < NP; p++)
            if (reset_n && port_req[p] != prev_req[p] && port_req[p] != port_ack[p]) begin
                if (exp_q.size() == 0)
                    chk("unexpected_req", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("req_port", p, e.port);
                    chk("req_a", port_a, e.a);
                    chk("req_ds", port_ds, e.ds);
                    chk("req_d", port_d, e.d);
                end
            end
        prev_req = port_req;
        if (!reset_n) port_ack = '0;
        else port_ack = (port_ack & hold) | (port_req & ~hold);
    end

    task automatic send(input string name, input logic [24:0] addr, input logic [7:0] data, input int exp_lat, input bit ovr);
        int lat;
        lat = 0;
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr = 1'b1;
        do begin
            @(negedge clk_sys);
            lat++;
            if (ovr && lat == 4) ioctl_wr = 1'b0;
            if (ovr && lat == 5) ioctl_wr = 1'b1;
        end while (!ioctl_ack && lat < 50);
        chk({name, "_lat"}, lat, exp_lat);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk({name, "_ackw"}, ioctl_ack, 0);
    endtask

    initial begin
        repeat (20000) @(posedge clk_sys);
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        hold = '0;
        region_base = {25'h70000, 25'h58000, 25'h10000, 25'h00000};
        region_mode = {2'd3, 2'd1, 2'd2, 2'd0};
        region_lg2  = {5'd0, 5'd16, 5'd16, 5'd0};
        region_port = {2'd0, 2'd0, 2'd1, 2'd0};
        repeat (3) @(negedge clk_sys);
        chk("rst_ack", ioctl_ack, 0);
        chk("rst_req", port_req, 0);
        chk("rst_loaded", rom_loaded, 0);
        chk("rst_core", core_reset, 1);
        chk("rst_ovr", err_overrun, 0);
        chk("rst_tmo", err_timeout, 0);
        chk("rst_a", port_a, 0);
        chk("rst_ds", port_ds, 0);
        chk("rst_d", port_d, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        ioctl_downl = 1'b1;
        @(negedge clk_sys);
        expect_txn(2'd0, 24'h000123, 2'b10, 16'hA5A5);
        send("lin", 25'h00123, 8'hA5, 3, 1'b0);
        expect_txn(2'd0, 24'h05800B, 2'b10, 16'h3C3C);
        send("il2", 25'h68005, 8'h3C, 3, 1'b0);
        expect_txn(2'd1, 24'h01000A, 2'b01, 16'h7E7E);
        send("il4", 25'h30002, 8'h7E, 3, 1'b0);
        expect_txn(2'd1, 24'h010000, 2'b01, 16'h5A5A);
        send("base_edge", 25'h10000, 8'h5A, 3, 1'b0);
        send("mode3", 25'h70010, 8'h99, 2, 1'b0);
        chk("ovr_clear", err_overrun, 0);
        chk("tmo_clear", err_timeout, 0);
        hold = 2'b01;
        expect_txn(2'd0, 24'h000200, 2'b01, 16'h1111);
        send("tmo", 25'h00200, 8'h11, 18, 1'b1);
        chk("ovr_set", err_overrun, 1);
        chk("tmo_set", err_timeout, 1);
        chk("req_after_tmo", port_req, 0);
        hold = '0;
        chk("core_in_dl", core_reset, 1);
        ioctl_downl = 1'b0;
        k = 0;
        while (!rom_loaded && k < 10) begin
            @(negedge clk_sys);
            k++;
        end
        chk("loaded", rom_loaded, 1);
        k = 0;
        do begin
            @(negedge clk_sys);
            k++;
        end while (!core_reset && k < 100);
        chk("pulse_at", k, RH);
        @(negedge clk_sys);
        chk("pulse_w", core_reset, 0);
        repeat (3) @(negedge clk_sys);
        chk("core_low", core_reset, 0);
        user_reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("ureset_core", core_reset, 1);
        chk("ureset_loaded", rom_loaded, 1);
        user_reset = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("rstn_loaded", rom_loaded, 0);
        chk("rstn_core", core_reset, 1);
        chk("rstn_ovr", err_overrun, 0);
        chk("rstn_tmo", err_timeout, 0);
        reset_n = 1'b1;
        region_base[24:0] = 25'h00100;
        @(negedge clk_sys);
        ioctl_downl = 1'b1;
        @(negedge clk_sys);
        send("below", 25'h00050, 8'h22, 2, 1'b0);
        send("mode3b", 25'h70005, 8'h33, 2, 1'b0);
        ioctl_downl = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("no_load", rom_loaded, 0);
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
